// File: rtl/risc5_test_pkg.sv
// rtl/risc5_test_pkg.sv - shared states, status codes and channel-index width helper for the test supervisor
package risc5_test_pkg;

    typedef enum logic [2:0] {
        S_HOLD,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    localparam logic [1:0] ST_RUN     = 2'b00;
    localparam logic [1:0] ST_PASS    = 2'b01;
    localparam logic [1:0] ST_FAIL    = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    // Channel index width, never narrower than one bit.
    function automatic int chw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/test_chan_tracker.sv
// rtl/test_chan_tracker.sv - sticky once-only capture of one channel's end and error levels
module test_chan_tracker
    import risc5_test_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic run_en,
    input  logic clr,
    input  logic ended,
    input  logic error,
    output logic end_nx,
    output logic err_nx,
    output logic end_flag,
    output logic err_flag
);

    // The next-state values are exported so the supervisor can judge on this cycle's captures.
    always_comb begin
        end_nx = end_flag;
        err_nx = err_flag;
        if (clr) begin
            end_nx = 1'b0;
            err_nx = 1'b0;
        end else if (run_en && ended && !end_flag) begin
            end_nx = 1'b1;
            err_nx = error;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            end_flag <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            end_flag <= end_nx;
            err_flag <= err_nx;
        end
    end

endmodule

// File: rtl/test_supervisor.sv
// rtl/test_supervisor.sv - test-run controller: DUT reset hold, end/error watch over NCH channels, timeout verdict
module test_supervisor
    import risc5_test_pkg::*;
#(
    parameter  int NCH         = 1,
    parameter  int RST_CYCLES  = 5,
    parameter  int TIMEOUT     = 600,
    parameter  int CNT_W       = 32,
    parameter  int STOP_ON_ERR = 0,
    localparam int CHW         = chw_of(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic [NCH-1:0]   ch_ended,
    input  logic [NCH-1:0]   ch_error,
    output logic             dut_rst,
    output logic             done,
    output logic             pass,
    output logic [1:0]       status,
    output logic [NCH-1:0]   end_map,
    output logic [NCH-1:0]   err_map,
    output logic [CHW-1:0]   first_err_ch,
    output logic [CNT_W-1:0] cycles
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t             state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [NCH-1:0]     end_nx;
    logic [NCH-1:0]     err_nx;
    logic [NCH-1:0]     new_err;
    logic [CHW-1:0]     fe_nx;
    logic               run_en;

    assign run_en = (state == S_RUN);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        test_chan_tracker u_trk (
            .clk      (clk),
            .rst_n    (rst_n),
            .run_en   (run_en),
            .clr      (restart),
            .ended    (ch_ended[i]),
            .error    (ch_error[i]),
            .end_nx   (end_nx[i]),
            .err_nx   (err_nx[i]),
            .end_flag (end_map[i]),
            .err_flag (err_map[i])
        );
    end

    always_comb begin
        new_err = err_nx & ~err_map;
        fe_nx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (new_err[i]) fe_nx = CHW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_HOLD;
            hold_cnt     <= '0;
            cycles       <= '0;
            first_err_ch <= '0;
            dut_rst      <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            status       <= ST_RUN;
        end else if (restart) begin
            state        <= S_HOLD;
            hold_cnt     <= '0;
            cycles       <= '0;
            first_err_ch <= '0;
            dut_rst      <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            status       <= ST_RUN;
        end else begin
            case (state)
                S_HOLD: begin
                    if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
                        state   <= S_RUN;
                        dut_rst <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (err_map == '0 && |new_err) first_err_ch <= fe_nx;
                    // The cycle count freezes at the verdict cycle, so it is only advanced when staying in RUN.
                    if (STOP_ON_ERR != 0 && |err_nx) begin
                        state  <= S_FAIL;
                        done   <= 1'b1;
                        status <= ST_FAIL;
                    end else if (&end_nx) begin
                        done <= 1'b1;
                        if (err_nx == '0) begin
                            state  <= S_PASS;
                            pass   <= 1'b1;
                            status <= ST_PASS;
                        end else begin
                            state  <= S_FAIL;
                            status <= ST_FAIL;
                        end
                    end else if (cycles == CNT_W'(TIMEOUT - 1)) begin
                        state  <= S_TIMEOUT;
                        done   <= 1'b1;
                        status <= ST_TIMEOUT;
                    end else if (cycles != '1) begin
                        cycles <= cycles + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_test_supervisor.sv
// tb/tb_test_supervisor.sv - self-checking bench for test_supervisor, STOP_ON_ERR=0 and =1 instances side by side
module tb_test_supervisor;

    localparam int TMO = 600;
    localparam int INF = 1 << 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic restart = 1'b0;
    logic [1:0] ch_ended = 2'b00;
    logic [1:0] ch_error = 2'b00;

    logic dut_rst0, done0, pass0, fe0;
    logic [1:0] status0, end_map0, err_map0;
    logic [31:0] cycles0;
    logic dut_rst1, done1, pass1, fe1;
    logic [1:0] status1, end_map1, err_map1;
    logic [31:0] cycles1;

    int total = 0;
    int bad = 0;
    int done_at[2];

    always #5 clk = ~clk;

    test_supervisor #(.NCH(2), .RST_CYCLES(5), .TIMEOUT(TMO), .CNT_W(32), .STOP_ON_ERR(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .restart(restart), .ch_ended(ch_ended), .ch_error(ch_error),
        .dut_rst(dut_rst0), .done(done0), .pass(pass0), .status(status0), .end_map(end_map0),
        .err_map(err_map0), .first_err_ch(fe0), .cycles(cycles0)
    );

    test_supervisor #(.NCH(2), .RST_CYCLES(5), .TIMEOUT(TMO), .CNT_W(32), .STOP_ON_ERR(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .restart(restart), .ch_ended(ch_ended), .ch_error(ch_error),
        .dut_rst(dut_rst1), .done(done1), .pass(pass1), .status(status1), .end_map(end_map1),
        .err_map(err_map1), .first_err_ch(fe1), .cycles(cycles1)
    );

    typedef struct {
        int e0; int e1; bit r0; bit r1;
        logic [1:0] st0; int cy0; logic [1:0] em0; logic [1:0] rm0; logic fe0;
        logic [1:0] st1; int cy1; logic [1:0] em1; logic [1:0] rm1; logic fe1;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " dut_rst"}, {dut_rst0, dut_rst1}, 2'b11);
        chk({tag, " done"}, {done0, done1, pass0, pass1}, 0);
        chk({tag, " status"}, {status0, status1}, 0);
        chk({tag, " maps"}, {end_map0, err_map0, end_map1, err_map1, fe0, fe1}, 0);
        chk({tag, " cycles"}, cycles0 + cycles1, 0);
    endtask

    // Counts clock edges until dut_rst drops; leaves the bench #1 into the first RUN cycle.
    task automatic wait_hold(input string tag);
        int n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            #1;
            if (!dut_rst0 && !dut_rst1) break;
        end
        chk({tag, " hold cycles"}, n, 5);
        chk({tag, " run start status/cycles"}, {status0, status1, cycles0, cycles1}, 0);
        chk({tag, " run start maps"}, {end_map0, err_map0, end_map1, err_map1}, 0);
    endtask

    // Inputs are held at "ended with error" through the hold period to show they are ignored.
    task automatic restart_seq(input string tag);
        restart = 1'b1;
        ch_ended = 2'b11;
        ch_error = 2'b11;
        @(posedge clk);
        #1;
        restart = 1'b0;
        check_idle({tag, " after restart"});
        wait_hold(tag);
    endtask

    task automatic drive_run(input int e0, input int e1, input bit r0, input bit r1);
        int e[2];
        bit r[2];
        int c = 0;
        e[0] = e0; e[1] = e1; r[0] = r0; r[1] = r1;
        done_at[0] = -1;
        done_at[1] = -1;
        while (c < TMO + 10 && (done_at[0] < 0 || done_at[1] < 0)) begin
            for (int i = 0; i < 2; i++) begin
                if (e[i] >= 0 && c > e[i]) begin
                    ch_ended[i] = 1'($urandom_range(0, 1));
                    ch_error[i] = 1'($urandom_range(0, 1));
                end else begin
                    ch_ended[i] = (e[i] >= 0 && c == e[i]);
                    ch_error[i] = (c == e[i]) ? r[i] : 1'($urandom_range(0, 1));
                end
            end
            @(posedge clk);
            #1;
            if (done0 && done_at[0] < 0) done_at[0] = c;
            if (done1 && done_at[1] < 0) done_at[1] = c;
            c++;
        end
        ch_ended = 2'b00;
        ch_error = 2'b00;
    endtask

    // Whole-run outcome from channel end times: first error time, all-ended time, timeout limit.
    task automatic model(input int e0, input int e1, input bit r0, input bit r1, input bit s,
                         output logic [1:0] st, output int cyc, output logic [1:0] em,
                         output logic [1:0] rm, output logic fe);
        int e[2];
        bit r[2];
        int t_all = 0;
        int t_err = INF;
        bit found = 0;
        e[0] = (e0 < 0) ? INF : e0;
        e[1] = (e1 < 0) ? INF : e1;
        r[0] = r0; r[1] = r1;
        for (int i = 0; i < 2; i++) begin
            if (e[i] > t_all) t_all = e[i];
            if (r[i] && e[i] < t_err) t_err = e[i];
        end
        if (s && t_err <= TMO - 1) begin
            st = 2'b10; cyc = t_err;
        end else if (t_all <= TMO - 1) begin
            cyc = t_all; st = (t_err <= t_all) ? 2'b10 : 2'b01;
        end else begin
            st = 2'b11; cyc = TMO - 1;
        end
        fe = 1'b0;
        for (int i = 0; i < 2; i++) begin
            em[i] = (e[i] <= cyc);
            rm[i] = r[i] && (e[i] <= cyc);
            if (!found && r[i] && e[i] == t_err && t_err <= cyc) begin
                fe = 1'(i);
                found = 1;
            end
        end
    endtask

    task automatic check_dut(input string tag, input int d, input logic [1:0] xst, input int xcyc,
                             input logic [1:0] xem, input logic [1:0] xrm, input logic xfe);
        logic [1:0] st, em, rm;
        logic fe, ps, dr;
        logic [31:0] cy;
        if (d == 0) begin
            st = status0; em = end_map0; rm = err_map0; fe = fe0; ps = pass0; dr = dut_rst0; cy = cycles0;
        end else begin
            st = status1; em = end_map1; rm = err_map1; fe = fe1; ps = pass1; dr = dut_rst1; cy = cycles1;
        end
        chk($sformatf("%s d%0d status", tag, d), st, xst);
        chk($sformatf("%s d%0d cycles", tag, d), cy, xcyc);
        chk($sformatf("%s d%0d end_map/err_map", tag, d), {em, rm}, {xem, xrm});
        chk($sformatf("%s d%0d first_err_ch", tag, d), fe, xfe);
        chk($sformatf("%s d%0d done cycle", tag, d), done_at[d], xcyc);
        chk($sformatf("%s d%0d pass/dut_rst", tag, d), {ps, dr}, {(xst == 2'b01), 1'b0});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{100, 200, 0, 0, 2'b01, 200, 2'b11, 2'b00, 0, 2'b01, 200, 2'b11, 2'b00, 0};
        vt[1] = '{300, 50, 0, 1, 2'b10, 300, 2'b11, 2'b10, 1, 2'b10, 50, 2'b10, 2'b10, 1};
        vt[2] = '{-1, -1, 0, 0, 2'b11, 599, 2'b00, 2'b00, 0, 2'b11, 599, 2'b00, 2'b00, 0};
        vt[3] = '{599, 599, 0, 0, 2'b01, 599, 2'b11, 2'b00, 0, 2'b01, 599, 2'b11, 2'b00, 0};
        vt[4] = '{599, -1, 0, 0, 2'b11, 599, 2'b01, 2'b00, 0, 2'b11, 599, 2'b01, 2'b00, 0};
        vt[5] = '{40, 40, 1, 1, 2'b10, 40, 2'b11, 2'b11, 0, 2'b10, 40, 2'b11, 2'b11, 0};
        vt[6] = '{100, 50, 1, 1, 2'b10, 100, 2'b11, 2'b11, 1, 2'b10, 50, 2'b10, 2'b10, 1};
        vt[7] = '{0, 0, 0, 0, 2'b01, 0, 2'b11, 2'b00, 0, 2'b01, 0, 2'b11, 2'b00, 0};
        vt[8] = '{599, 599, 0, 1, 2'b10, 599, 2'b11, 2'b10, 1, 2'b10, 599, 2'b11, 2'b10, 1};

        #20;
        check_idle("reset");
        #31;
        rst_n = 1'b1;
        wait_hold("release");

        for (int v = 0; v < 9; v++) begin
            drive_run(vt[v].e0, vt[v].e1, vt[v].r0, vt[v].r1);
            check_dut($sformatf("vec%0d", v), 0, vt[v].st0, vt[v].cy0, vt[v].em0, vt[v].rm0, vt[v].fe0);
            check_dut($sformatf("vec%0d", v), 1, vt[v].st1, vt[v].cy1, vt[v].em1, vt[v].rm1, vt[v].fe1);
            restart_seq($sformatf("vec%0d", v));
        end

        // Asynchronous reset in the middle of a run with captures already made.
        ch_ended = 2'b00;
        ch_error = 2'b00;
        repeat (20) @(posedge clk);
        #1;
        ch_ended = 2'b10;
        ch_error = 2'b10;
        repeat (10) @(posedge clk);
        #1;
        chk("midrun before reset", {cycles0, end_map0, err_map0, status1}, {32'd30, 2'b10, 2'b10, 2'b10});
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("midrun reset");
        ch_ended = 2'b00;
        ch_error = 2'b00;
        #5;
        rst_n = 1'b1;
        wait_hold("midrun release");

        for (int k = 0; k < 12; k++) begin
            int e0, e1;
            bit r0, r1;
            logic [1:0] st, em, rm;
            logic fe;
            int cyc;
            e0 = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 640));
            if ($urandom_range(0, 4) == 0) e1 = -1;
            else if ($urandom_range(0, 3) == 0) e1 = e0;
            else e1 = int'($urandom_range(0, 640));
            r0 = ($urandom_range(0, 2) == 0);
            r1 = ($urandom_range(0, 2) == 0);
            drive_run(e0, e1, r0, r1);
            model(e0, e1, r0, r1, 1'b0, st, cyc, em, rm, fe);
            check_dut($sformatf("rand%0d", k), 0, st, cyc, em, rm, fe);
            model(e0, e1, r0, r1, 1'b1, st, cyc, em, rm, fe);
            check_dut($sformatf("rand%0d", k), 1, st, cyc, em, rm, fe);
            restart_seq($sformatf("rand%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
